// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command sequencer: opcodes, FSM state
// encoding, error-bit positions, the queued command layout and error masking.
package calc_pkg;

  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_GND    = 4'b0001;
  localparam logic [3:0] OP_ADD    = 4'b0010;
  localparam logic [3:0] OP_SUB    = 4'b0011;
  localparam logic [3:0] OP_MUL    = 4'b0100;
  localparam logic [3:0] OP_DIV    = 4'b0101;
  localparam logic [3:0] OP_MOD    = 4'b0110;
  localparam logic [3:0] OP_PRESET = 4'b1110;
  localparam logic [3:0] OP_RESET  = 4'b1111;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_SETTLE  = 2'd2;
  localparam logic [1:0] ST_RESPOND = 2'd3;

  localparam int ERR_OVF_BIT  = 0;
  localparam int ERR_DIV0_BIT = 1;

  localparam int CMD_W = 20;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] data;
  } cmd_t;

  // Overflow only means something for ADD/SUB, divide-by-zero only for DIV/MOD.
  function automatic logic [1:0] mask_err(input logic [3:0] op, input logic [1:0] err);
    logic [1:0] m;
    m = '0;
    if (op == OP_ADD || op == OP_SUB) m[ERR_OVF_BIT]  = err[ERR_OVF_BIT];
    if (op == OP_DIV || op == OP_MOD) m[ERR_DIV0_BIT] = err[ERR_DIV0_BIT];
    return m;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with power-of-two depth; pointers wrap naturally
// and a separate occupancy count drives full/empty.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop  & ~o_empty;

  // NOTE: the storage array is deliberately not reset; r_count alone says which
  // entries are valid, so the array can map onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/calc_sequencer.sv
// Queues calculator commands and runs them one at a time: issue for a single
// cycle, wait SETTLE cycles, then hold the result until it is consumed.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [3:0]  i_cmd_op,
  input  logic [15:0] i_cmd_data,
  output logic [3:0]  o_calc_op,
  output logic [15:0] o_calc_in1,
  input  logic [31:0] i_calc_out,
  input  logic [1:0]  i_calc_err,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic [1:0]  o_rsp_err,
  output logic [3:0]  o_rsp_op,
  output logic        o_busy
);

  localparam int            CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  logic [1:0]            r_state;
  cmd_t                  r_cmd;
  logic [CW-1:0]         r_settle_cnt;
  logic [1:0]            r_err_cap;
  logic                  r_rsp_valid;
  logic [31:0]           r_rsp_data;
  logic [1:0]            r_rsp_err;
  logic [3:0]            r_rsp_op;

  cmd_t                  w_fifo_in;
  cmd_t                  w_fifo_out;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [$clog2(DEPTH):0] w_fifo_count;
  logic                  w_push;
  logic                  w_pop;

  assign w_fifo_in   = '{op: i_cmd_op, data: i_cmd_data};
  assign o_cmd_ready = ~i_rst & ~w_fifo_full;
  assign w_push      = i_cmd_valid & o_cmd_ready;
  assign w_pop       = (r_state == ST_IDLE) & ~w_fifo_empty;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_fifo_in),
    .o_data  (w_fifo_out),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cmd        <= '0;
      r_settle_cnt <= '0;
      r_err_cap    <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_err    <= '0;
      r_rsp_op     <= OP_NOP;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_cmd   <= w_fifo_out;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Error flags are only valid while the opcode is on the bus.
          r_err_cap    <= mask_err(r_cmd.op, i_calc_err);
          r_settle_cnt <= '0;
          r_state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_settle_cnt == SETTLE_LAST) begin
            r_rsp_data  <= i_calc_out;
            r_rsp_err   <= r_err_cap;
            r_rsp_op    <= r_cmd.op;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESPOND;
          end else begin
            r_settle_cnt <= r_settle_cnt + CW'(1);
          end
        end
        ST_RESPOND: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_calc_op   = (r_state == ST_ISSUE) ? r_cmd.op   : OP_NOP;
  assign o_calc_in1  = (r_state == ST_ISSUE) ? r_cmd.data : '0;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_op    = r_rsp_op;
  assign o_busy      = (r_state != ST_IDLE) | (w_fifo_count != '0);

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: attaches an accumulator calculator model, tracks
// issued commands and expected responses, and runs directed scenarios.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int DEPTH  = 4;
  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [15:0] cmd_data = '0;
  logic [3:0]  calc_op;
  logic [15:0] calc_in1;
  logic [31:0] calc_out;
  logic [1:0]  calc_err;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  logic [3:0]  rsp_op;
  logic        busy;

  always #5 clk = ~clk;

  calc_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_op    (cmd_op),
    .i_cmd_data  (cmd_data),
    .o_calc_op   (calc_op),
    .o_calc_in1  (calc_in1),
    .i_calc_out  (calc_out),
    .i_calc_err  (calc_err),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rsp_err   (rsp_err),
    .o_rsp_op    (rsp_op),
    .o_busy      (busy)
  );

  // Calculator: result = IN1 <op> ACC, accumulator is never touched by RST.
  typedef struct packed {
    logic [1:0]  err;
    logic [31:0] res;
  } alu_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  err;
    logic [3:0]  op;
  } rsp_t;

  function automatic alu_t alu(input logic [3:0] op, input logic [15:0] in1, input logic [31:0] acc);
    alu_t        r;
    logic [32:0] s;
    logic [63:0] p;
    r.err = '0;
    r.res = acc;
    case (op)
      OP_GND, OP_RESET: r.res = '0;
      OP_PRESET: r.res = {16'h0, in1};
      OP_ADD: begin
        s = {1'b0, acc} + {17'h0, in1};
        r.res = s[31:0];
        r.err[0] = s[32];
      end
      OP_SUB: begin
        r.res = {16'h0, in1} - acc;
        r.err[0] = ({16'h0, in1} < acc);
      end
      OP_MUL: begin
        p = {32'h0, acc} * {48'h0, in1};
        r.res = p[31:0];
        r.err[0] = |p[63:32];
      end
      OP_DIV: begin
        if (acc == 0) begin r.err[1] = 1'b1; r.res = '0; end
        else r.res = {16'h0, in1} / acc;
      end
      OP_MOD: begin
        if (acc == 0) begin r.err[1] = 1'b1; r.res = '0; end
        else r.res = {16'h0, in1} % acc;
      end
      default: ;
    endcase
    return r;
  endfunction

  logic [31:0] calc_acc = '0;
  logic [1:0]  err_inject = '0;
  alu_t        calc_now;

  always_comb calc_now = alu(calc_op, calc_in1, calc_acc);
  assign calc_out = calc_acc;
  assign calc_err = (calc_op != OP_NOP) ? (calc_now.err | err_inject) : 2'b00;
  always @(posedge clk) if (calc_op != OP_NOP) calc_acc <= calc_now.res;

  // Scoreboard state
  int          n_checks = 0;
  int          n_pass   = 0;
  cmd_t        iq[$];
  rsp_t        exp_q[$];
  rsp_t        rsp_log[$];
  logic [31:0] mdl_acc = '0;
  bit          seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: event missing or timed out at %0t", name, $time);
  endtask

  function automatic logic [1:0] expect_err(input logic [3:0] op, input logic [1:0] raw);
    logic [1:0] e;
    e = 2'b00;
    if (op inside {OP_ADD, OP_SUB}) e[0] = raw[0];
    if (op inside {OP_DIV, OP_MOD}) e[1] = raw[1];
    return e;
  endfunction

  // Compare process: every issue and every response, every cycle.
  initial begin
    cmd_t c;
    alu_t a;
    rsp_t e;
    rsp_t cur;
    rsp_t held;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        iq.delete();
        exp_q.delete();
        seen = 1'b0;
      end else begin
        if (calc_op != OP_NOP) begin
          check("no_issue_while_rsp", 64'(rsp_valid), 64'(0));
          if (iq.size() == 0) fail("issue_unexpected");
          else begin
            c = iq.pop_front();
            check("issue_op", 64'(calc_op), 64'(c.op));
            check("issue_in1", 64'(calc_in1), 64'(c.data));
            a = alu(c.op, c.data, mdl_acc);
            mdl_acc = a.res;
            e.data = a.res;
            e.err  = expect_err(c.op, a.err | err_inject);
            e.op   = c.op;
            exp_q.push_back(e);
          end
        end else begin
          check("idle_in1_zero", 64'(calc_in1), 64'(0));
        end
        if (rsp_valid) begin
          cur.data = rsp_data;
          cur.err  = rsp_err;
          cur.op   = rsp_op;
          if (!seen) begin
            if (exp_q.size() == 0) fail("rsp_unexpected");
            else begin
              e = exp_q.pop_front();
              check("rsp_data", 64'(cur.data), 64'(e.data));
              check("rsp_err", 64'(cur.err), 64'(e.err));
              check("rsp_op", 64'(cur.op), 64'(e.op));
            end
            rsp_log.push_back(cur);
            held = cur;
          end else begin
            check("rsp_stable", 64'(cur), 64'(held));
          end
          seen = !rsp_ready;
        end else begin
          if (seen) fail("rsp_dropped");
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_cmd(input logic [3:0] op, input logic [15:0] d);
    int budget;
    budget = 300;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(negedge clk);
    while (!cmd_ready && budget > 0) begin
      budget--;
      @(negedge clk);
    end
    if (budget == 0) begin
      fail("push_timeout");
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    iq.push_back('{op: op, data: d});
    #1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_data  = '0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) break;
    end
    if (k == 1000) fail("wait_idle_timeout");
  endtask

  task automatic check_log(input string name, input int idx, input logic [31:0] d,
                           input logic [1:0] e, input logic [3:0] op);
    if (idx >= rsp_log.size()) fail(name);
    else begin
      check({name, "_data"}, 64'(rsp_log[idx].data), 64'(d));
      check({name, "_err"}, 64'(rsp_log[idx].err), 64'(e));
      check({name, "_op"}, 64'(rsp_log[idx].op), 64'(op));
    end
  endtask

  initial begin
    int base;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_calc_op", 64'(calc_op), 64'(0));
    check("rst_calc_in1", 64'(calc_in1), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_data", 64'(rsp_data), 64'(0));
    check("rst_rsp_err", 64'(rsp_err), 64'(0));
    check("rst_rsp_op", 64'(rsp_op), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    sync();
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(cmd_ready), 64'(1));

    // Latency from accept into an empty FIFO, then RESET/ADD pair
    sync();
    push_cmd(OP_RESET, 16'd0);
    @(negedge clk);
    check("lat_idle_nop", 64'(calc_op), 64'(OP_NOP));
    @(negedge clk);
    check("lat_issue_op", 64'(calc_op), 64'(OP_RESET));
    repeat (SETTLE) begin
      @(negedge clk);
      check("lat_settle_no_rsp", 64'(rsp_valid), 64'(0));
    end
    @(negedge clk);
    check("lat_rsp_valid", 64'(rsp_valid), 64'(1));
    sync();
    push_cmd(OP_ADD, 16'd10);
    wait_idle();
    check_log("pair_reset", 0, 32'd0, 2'b00, OP_RESET);
    check_log("pair_add10", 1, 32'd10, 2'b00, OP_ADD);

    // MUL from 10, then SUB below zero
    base = rsp_log.size();
    sync();
    push_cmd(OP_RESET, 16'd0);
    push_cmd(OP_ADD, 16'd10);
    push_cmd(OP_MUL, 16'd15);
    push_cmd(OP_RESET, 16'd0);
    push_cmd(OP_ADD, 16'd10);
    push_cmd(OP_SUB, 16'd3);
    wait_idle();
    check_log("mul150", base + 2, 32'd150, 2'b00, OP_MUL);
    check_log("sub_neg", base + 5, 32'hFFFF_FFF9, 2'b01, OP_SUB);

    // Divide by zero
    base = rsp_log.size();
    sync();
    push_cmd(OP_RESET, 16'd0);
    push_cmd(OP_DIV, 16'd7);
    wait_idle();
    check_log("div0", base + 1, 32'd0, 2'b10, OP_DIV);

    // Error masking with both error lines forced, plus an undefined opcode
    base = rsp_log.size();
    sync();
    err_inject = 2'b11;
    push_cmd(OP_RESET, 16'd0);
    push_cmd(OP_ADD, 16'd1);
    push_cmd(OP_MUL, 16'd3);
    push_cmd(OP_MOD, 16'd2);
    push_cmd(4'b1010, 16'd5);
    wait_idle();
    err_inject = 2'b00;
    check_log("mask_reset", base + 0, 32'd0, 2'b00, OP_RESET);
    check_log("mask_add", base + 1, 32'd1, 2'b01, OP_ADD);
    check_log("mask_mul", base + 2, 32'd3, 2'b00, OP_MUL);
    check_log("mask_mod", base + 3, 32'd2, 2'b10, OP_MOD);
    check_log("mask_undef", base + 4, 32'd2, 2'b00, 4'b1010);

    // Back-pressure: response held, FIFO fills
    base = rsp_log.size();
    sync();
    rsp_ready = 1'b0;
    push_cmd(OP_RESET, 16'd0);
    push_cmd(OP_ADD, 16'd5);
    push_cmd(OP_MUL, 16'd3);
    push_cmd(OP_SUB, 16'd20);
    push_cmd(OP_MOD, 16'd7);
    @(negedge clk);
    check("bp_ready_full", 64'(cmd_ready), 64'(0));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_calc_nop", 64'(calc_op), 64'(OP_NOP));
      check("bp_ready_low", 64'(cmd_ready), 64'(0));
      check("bp_valid_held", 64'(rsp_valid), 64'(1));
    end
    sync();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rel_ready_pre", 64'(cmd_ready), 64'(0));
    @(negedge clk);
    check("rel_ready_idle", 64'(cmd_ready), 64'(0));
    @(negedge clk);
    check("rel_ready_rise", 64'(cmd_ready), 64'(1));
    check("rel_next_issue", 64'(calc_op), 64'(OP_ADD));
    sync();
    push_cmd(OP_ADD, 16'd9);
    wait_idle();
    check_log("bp_first", base + 0, 32'd0, 2'b00, OP_RESET);
    check_log("bp_sub", base + 3, 32'd5, 2'b00, OP_SUB);
    check_log("bp_last", base + 5, 32'd11, 2'b00, OP_ADD);

    // Reset while settling: in-flight and queued commands are discarded
    sync();
    push_cmd(OP_ADD, 16'd1);
    push_cmd(OP_ADD, 16'd1);
    @(negedge clk);
    check("mid_rst_issue", 64'(calc_op), 64'(OP_ADD));
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_calc_op", 64'(calc_op), 64'(0));
    check("mid_rst_calc_in1", 64'(calc_in1), 64'(0));
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_ready", 64'(cmd_ready), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", 64'(rsp_valid), 64'(0));
      check("post_rst_nop", 64'(calc_op), 64'(OP_NOP));
      check("post_rst_idle", 64'(busy), 64'(0));
    end

    // 16 back-to-back increments across pointer wrap
    sync();
    push_cmd(OP_RESET, 16'd0);
    base = rsp_log.size();
    for (int i = 0; i < 16; i++) push_cmd(OP_ADD, 16'd1);
    wait_idle();
    for (int i = 0; i < 16; i++)
      check_log($sformatf("inc%0d", i), base + 1 + i, 32'(i + 1), 2'b00, OP_ADD);

    repeat (3) @(negedge clk);
    check("end_no_pending_issue", 64'(iq.size()), 64'(0));
    check("end_no_pending_rsp", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
